char_stream_sequencer: RTL and testbench
========================================

// Module: char_stream_sequencer
// PURPOSE
//   Controls the shared character memory in two phases: LOAD, then PLAY.
//   LOAD: captures 6-bit characters from the serial text reader and writes them
//   to consecutive addresses, one write per char_ready rising edge.
//   PLAY (after eof): reads the characters back in order and hands each one to
//   the plotter stroke engine over a valid/accept handshake.
//   Owns the memory address mux, replacing the free-running index counter.
// PARAMETERS
//   ADDR_W       12  memory address width; capacity is 2**ADDR_W characters
//   CHAR_W        6  character code width
//   MEM_LAT       1  synchronous memory read latency, in clk cycles (1 or 2)
//   SYNC_STAGES   2  synchroniser depth for char_ready and eof
// PORTS
//   clk          in   1       system clock, rising edge
//   resetn       in   1       asynchronous, active-low reset
//   char_ready   in   1       reader strobe, async to clk; rising edge = new char
//   next_char    in   CHAR_W  character code, stable while char_ready is high
//   eof          in   1       reader end-of-file level, async to clk
//   restart      in   1       synchronous pulse: discard buffer, return to LOAD
//   mem_addr     out  ADDR_W  memory address
//   mem_wdata    out  CHAR_W  memory write data
//   mem_wren     out  1       memory write enable, 1-cycle pulse
//   mem_rdata    in   CHAR_W  memory read data, MEM_LAT cycles after mem_addr
//   char_valid   out  1       char_out holds a character for the plotter
//   char_out     out  CHAR_W  character presented to the plotter
//   char_accept  in   1       plotter takes char_out when char_valid && char_accept
//   char_count   out  ADDR_W+1  number of characters stored
//   playing      out  1       high in READ and PRESENT
//   done         out  1       high in DONE
//   overflow     out  1       sticky; a character was dropped because the buffer was full
// BEHAVIOUR
//   Reset: all outputs 0; state LOAD; count 0; read pointer 0; synchronisers cleared.
//   Sync: char_ready and eof each pass through SYNC_STAGES flops.
//     cr_rise = synced char_ready high now, low one cycle earlier.
//     eof_s   = synced eof level.
//     next_char is sampled when cr_rise fires.
//   States:
//     LOAD
//       On cr_rise with count < 2**ADDR_W: write for one cycle
//         (mem_wren=1, mem_addr=count, mem_wdata=next_char); count increments next cycle.
//       On cr_rise with count == 2**ADDR_W: no write; set overflow.
//       On eof_s: go to READ if count > 0, otherwise go to DONE.
//       cr_rise and eof_s in the same cycle: the write is performed, then the
//         transition is taken using the incremented count.
//     READ
//       mem_addr = rptr; wait MEM_LAT cycles.
//       Then register mem_rdata into char_out, set char_valid, go to PRESENT.
//     PRESENT
//       char_valid and char_out hold steady until char_accept is seen.
//       On accept: char_valid drops next cycle; rptr increments.
//       If rptr+1 == count go to DONE, otherwise go to READ.
//       Per-character throughput is 2+MEM_LAT cycles when char_accept is tied high.
//     DONE
//       done=1; no memory access; stay until restart or reset.
//   Memory control:
//     mem_wren is asserted only in LOAD and never during READ/PRESENT.
//     mem_addr = count in LOAD and rptr otherwise.
//   restart (any state): next cycle, count=0, rptr=0, overflow=0, char_valid=0,
//     state=LOAD. restart has priority over every other event in that cycle.
//   cr_rise outside LOAD is ignored. eof is level-sensitive, examined only in LOAD.
//   Asserting resetn mid-PLAY drops char_valid immediately (asynchronously).
//   Width rule: char_count is ADDR_W+1 bits so the full state (4096) is representable.
//     The write address is count[ADDR_W-1:0].
// STRUCTURE
//   Shared package plotter_pkg:
//     state enum {LOAD, READ, PRESENT, DONE};
//     CHAR_W, ADDR_W defaults;
//     CHAR_SPACE=6'd0 code constant.
//   Sub-module: edge_sync (SYNC_STAGES-deep synchroniser plus rising-edge detect).
//     Instanced for char_ready; eof uses only its level output.
//   The memory itself stays outside this block.
// TESTING
//   1 Write 3 chars 5,17,42 (char_ready pulses >= 4 clk wide), then eof. Check:
//       mem writes at addresses 0,1,2;
//       char_out sequence 5,17,42;
//       done=1 after the third accept.
//   2 eof with no chars written: state reaches DONE in <= SYNC_STAGES+1 cycles;
//       char_valid never asserts.
//   3 Plotter holds char_accept low for 20 cycles in PRESENT:
//       char_out stays stable and char_valid stays high; after accept, rptr advances by exactly 1.
//   4 Fill 4096 chars, then one more pulse: overflow=1, char_count=4096, no 4097th write;
//       playback ends with char 4095.
//   5 cr_rise and eof_s in the same cycle after 2 chars:
//       the third char is written; playback emits 3 chars.
//   6 resetn low mid-PRESENT, then high:
//       outputs are 0 and state is LOAD;
//       a later restart pulse in DONE clears count and overflow.

Source files
------------

// File: rtl/plotter_pkg.sv
// Shared definitions for the plotter character path: sequencer states,
// default widths and the blank character code.
package plotter_pkg;
  typedef enum logic [1:0] {LOAD, READ, PRESENT, DONE} state_t;

  localparam int CHAR_W_DEF = 6;
  localparam int ADDR_W_DEF = 12;
  localparam logic [5:0] CHAR_SPACE = 6'd0;
endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchroniser for an asynchronous level, with a rising-edge
// strobe derived from the synchronised level.
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic level,
  output logic rise
);
  logic [STAGES-1:0] sr;
  logic              prev;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sr   <= '0;
      prev <= 1'b0;
    end else begin
      sr   <= (sr << 1) | STAGES'(din);
      prev <= sr[STAGES-1];
    end
  end

  assign level = sr[STAGES-1];
  assign rise  = level & ~prev;
endmodule

// File: rtl/char_stream_sequencer.sv
// Two-phase owner of the character memory: LOAD stores reader characters at
// consecutive addresses, PLAY reads them back and hands them to the plotter.
module char_stream_sequencer
  import plotter_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int CHAR_W      = CHAR_W_DEF,
  parameter int MEM_LAT     = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              char_ready,
  input  logic [CHAR_W-1:0] next_char,
  input  logic              eof,
  input  logic              restart,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [CHAR_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [CHAR_W-1:0] mem_rdata,
  output logic              char_valid,
  output logic [CHAR_W-1:0] char_out,
  input  logic              char_accept,
  output logic [ADDR_W:0]   char_count,
  output logic              playing,
  output logic              done,
  output logic              overflow
);
  state_t          state, state_nxt;
  logic [ADDR_W:0]   count, count_inc;
  logic [ADDR_W-1:0] rptr;
  logic [1:0]        wcnt;
  logic cr_rise, cr_level_unused, eof_s, eof_rise_unused;
  logic wr, take, last, lat_hit;

  edge_sync #(.STAGES(SYNC_STAGES)) u_cr_sync (
    .clk(clk), .resetn(resetn), .din(char_ready),
    .level(cr_level_unused), .rise(cr_rise)
  );

  edge_sync #(.STAGES(SYNC_STAGES)) u_eof_sync (
    .clk(clk), .resetn(resetn), .din(eof),
    .level(eof_s), .rise(eof_rise_unused)
  );

  // count[ADDR_W] set means the buffer is full; further characters are dropped.
  assign wr        = (state == LOAD) && cr_rise && !count[ADDR_W] && !restart;
  assign count_inc = count + (ADDR_W+1)'(wr);
  assign take      = (state == PRESENT) && char_valid && char_accept;
  assign last      = ({1'b0, rptr} + (ADDR_W+1)'(1)) == count;
  assign lat_hit   = wcnt == 2'(MEM_LAT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= LOAD;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_wren  = wr;
    mem_wdata = wr ? next_char : '0;
    mem_addr  = (state == LOAD) ? count[ADDR_W-1:0] : rptr;
    case (state)
      LOAD:    if (eof_s) state_nxt = (count_inc != '0) ? READ : DONE;
      READ:    if (lat_hit) state_nxt = PRESENT;
      PRESENT: if (take) state_nxt = last ? DONE : READ;
      DONE:    state_nxt = DONE;
      default: state_nxt = LOAD;
    endcase
    if (restart) state_nxt = LOAD;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count      <= '0;
      rptr       <= '0;
      overflow   <= 1'b0;
      char_valid <= 1'b0;
      char_out   <= CHAR_W'(CHAR_SPACE);
      wcnt       <= '0;
    end else if (restart) begin
      count      <= '0;
      rptr       <= '0;
      overflow   <= 1'b0;
      char_valid <= 1'b0;
      wcnt       <= '0;
    end else begin
      case (state)
        LOAD: begin
          count <= count_inc;
          wcnt  <= '0;
          if (cr_rise && count[ADDR_W]) overflow <= 1'b1;
        end
        // Address is held for MEM_LAT+1 cycles so the read data is settled
        // in the cycle it is captured.
        READ: begin
          if (lat_hit) begin
            char_out   <= mem_rdata;
            char_valid <= 1'b1;
            wcnt       <= '0;
          end else begin
            wcnt <= wcnt + 2'd1;
          end
        end
        PRESENT: begin
          if (take) begin
            char_valid <= 1'b0;
            rptr       <= rptr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign char_count = count;
  assign playing    = (state == READ) || (state == PRESENT);
  assign done       = (state == DONE);
endmodule

// File: tb/tb_char_stream_sequencer.sv
// Directed bench: stimulus pushes expected memory writes and plotter
// characters into queues, a negedge monitor pops and compares them.
module tb_char_stream_sequencer;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        char_ready = 1'b0;
  logic [5:0]  next_char = '0;
  logic        eof = 1'b0;
  logic        restart = 1'b0;
  logic [11:0] mem_addr;
  logic [5:0]  mem_wdata;
  logic        mem_wren;
  logic [5:0]  mem_rdata;
  logic        char_valid;
  logic [5:0]  char_out;
  logic        char_accept = 1'b0;
  logic [12:0] char_count;
  logic        playing, done, overflow;

  int checks = 0;
  int fails  = 0;
  int exp_count = 0;
  int nacc = 0;
  int last_char = -1;
  int wq_addr[$];
  int wq_data[$];
  int rq[$];

  logic [5:0] mem [4096];

  always #5 clk = ~clk;

  char_stream_sequencer dut (
    .clk(clk), .resetn(resetn), .char_ready(char_ready), .next_char(next_char),
    .eof(eof), .restart(restart), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wren(mem_wren), .mem_rdata(mem_rdata), .char_valid(char_valid),
    .char_out(char_out), .char_accept(char_accept), .char_count(char_count),
    .playing(playing), .done(done), .overflow(overflow)
  );

  // One-cycle-latency synchronous memory
  always @(posedge clk) begin
    if (mem_wren) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (mem_wren) begin
        if (wq_addr.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_write: got addr %0d data %0d expected no write", mem_addr, mem_wdata);
        end else begin
          chk("write_addr", 32'(mem_addr), wq_addr.pop_front());
          chk("write_data", 32'(mem_wdata), wq_data.pop_front());
        end
      end
      if (char_valid && char_accept) begin
        nacc++;
        last_char = int'(char_out);
        if (rq.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_char: got %0d expected none", char_out);
        end else begin
          chk("char_out", 32'(char_out), rq.pop_front());
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [5:0] c, input int w, input bit stored);
    if (stored) begin
      wq_addr.push_back(exp_count);
      wq_data.push_back(int'(c));
      rq.push_back(int'(c));
      exp_count++;
    end
    next_char = c; char_ready = 1'b1;
    tick(w);
    char_ready = 1'b0;
    tick(w);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin tick(1); n++; end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic restart_pulse();
    eof = 1'b0;
    tick(4);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    exp_count = 0; nacc = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_valid, stable;
    int n;
    // Reset state
    tick(2);
    chk("rst_outputs", {mem_addr, mem_wdata, mem_wren, char_valid, char_out}, 32'd0);
    chk("rst_status", {char_count, playing, done, overflow}, 32'd0);
    resetn = 1'b1;
    char_accept = 1'b1;
    tick(2);

    // 1: three chars then eof
    send(6'd5, 4, 1'b1); send(6'd17, 4, 1'b1); send(6'd42, 4, 1'b1);
    chk("t1_count", 32'(char_count), 32'd3);
    eof = 1'b1;
    wait_done("t1_done", 100);
    chk("t1_naccepts", nacc, 3);
    chk("t1_queues_empty", wq_addr.size() + rq.size(), 0);
    restart_pulse();
    chk("t1_restart_count", 32'(char_count), 32'd0);

    // 2: eof with empty buffer
    saw_valid = 1'b0;
    eof = 1'b1;
    n = 0;
    while (!done && n < 3) begin tick(1); n++; saw_valid |= char_valid; end
    chk("t2_done_fast", 32'(done), 32'd1);
    tick(5);
    saw_valid |= char_valid;
    chk("t2_no_valid", 32'(saw_valid), 32'd0);
    restart_pulse();

    // 5: third char's edge coincides with eof
    send(6'd7, 4, 1'b1); send(6'd8, 4, 1'b1);
    wq_addr.push_back(2); wq_data.push_back(9); rq.push_back(9); exp_count++;
    next_char = 6'd9; char_ready = 1'b1; eof = 1'b1;
    tick(4);
    char_ready = 1'b0;
    wait_done("t5_done", 100);
    chk("t5_naccepts", nacc, 3);
    chk("t5_count", 32'(char_count), 32'd3);
    restart_pulse();

    // 3: plotter stalls for 20 cycles, then 6: reset mid-PRESENT
    send(6'd11, 4, 1'b1); send(6'd33, 4, 1'b1);
    char_accept = 1'b0;
    eof = 1'b1;
    n = 0;
    while (!char_valid && n < 50) begin tick(1); n++; end
    chk("t3_valid", 32'(char_valid), 32'd1);
    stable = 1'b1;
    repeat (20) begin
      tick(1);
      if (!char_valid || char_out !== 6'd11 || mem_addr !== 12'd0) stable = 1'b0;
    end
    chk("t3_stable", 32'(stable), 32'd1);
    char_accept = 1'b1;
    tick(1);
    char_accept = 1'b0;
    chk("t3_rptr_step", 32'(mem_addr), 32'd1);
    chk("t3_valid_drop", 32'(char_valid), 32'd0);
    n = 0;
    while (!char_valid && n < 50) begin tick(1); n++; end
    chk("t3_second_valid", 32'(char_out), 32'd33);
    resetn = 1'b0;
    #2;
    chk("t6_async_valid", 32'(char_valid), 32'd0);
    wq_addr.delete(); wq_data.delete(); rq.delete();
    exp_count = 0; nacc = 0;
    eof = 1'b0; char_accept = 1'b1;
    tick(2);
    resetn = 1'b1;
    tick(1);
    chk("t6_outputs", {mem_addr, mem_wdata, mem_wren, char_valid, char_out}, 32'd0);
    chk("t6_status", {char_count, playing, done, overflow}, 32'd0);

    // 4: fill the buffer, one extra char overflows
    for (int i = 0; i < 4096; i++) send(6'(i), 3, 1'b1);
    send(6'd1, 3, 1'b0);
    chk("t4_overflow", 32'(overflow), 32'd1);
    chk("t4_count", 32'(char_count), 32'd4096);
    eof = 1'b1;
    wait_done("t4_done", 20000);
    chk("t4_naccepts", nacc, 4096);
    chk("t4_last_char", last_char, 63);
    chk("t4_queues_empty", wq_addr.size() + rq.size(), 0);
    chk("t4_overflow_held", 32'(overflow), 32'd1);

    // 6: restart from DONE clears count and overflow
    restart_pulse();
    chk("t6_restart_count", 32'(char_count), 32'd0);
    chk("t6_restart_overflow", 32'(overflow), 32'd0);
    chk("t6_restart_done", 32'(done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
